cv32e40x_clock_gate_ctrl: RTL

- Sleep/wake sequencer that drives the enable of a core-level clock gate cell (cv32e40x_clock_gate en_i).
- Gates the clock only after a sleep request persists for a programmable idle window with all requesters idle.
- Restores the clock on wake with a settle delay before handing control back.
- Sits in the always-on clock domain next to the gate cell; also keeps a saturating count of gated cycles for power profiling.

---
 rtl/cv32e40x_clock_gate_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/cv32e40x_clock_gate_ctrl.sv
// Sleep/wake sequencer for the core clock gate enable. Gates only after a qualified idle
// window, restores the clock with a settle delay, and counts gated cycles.
module cv32e40x_clock_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] busy_i,
  input  logic               sleep_req_i,
  input  logic               wake_req_i,
  input  logic               sleep_cnt_clr_i,
  output logic               clk_en_o,
  output logic               sleeping_o,
  output logic               wake_ack_o,
  output logic [CNT_W-1:0]   sleep_cnt_o,
  output logic [1:0]         state_o
);

  localparam int MAX_C = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW    = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);
  localparam logic [CW-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? CW'(IDLE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CW'(WAKE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ack_nxt;
  logic          qualified_idle;

  // Wake requests always block gating, even while the core asks to sleep.
  assign qualified_idle = sleep_req_i && (busy_i == '0) && !wake_req_i;
  assign state_o        = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (qualified_idle) begin
          if (IDLE_CYCLES > 0) begin
            state_nxt = DRAIN;
            cnt_nxt   = IDLE_LOAD;
          end else begin
            state_nxt = SLEEP;
          end
        end
      end
      DRAIN: begin
        if (!qualified_idle) begin
          state_nxt = RUN;
        end else if (cnt == '0) begin
          state_nxt = SLEEP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      SLEEP: begin
        if (wake_req_i) begin
          if (WAKE_CYCLES > 0) begin
            state_nxt = WAKE;
            cnt_nxt   = WAKE_LOAD;
          end else begin
            state_nxt = RUN;
            ack_nxt   = 1'b1;
          end
        end
      end
      WAKE: begin
        if (cnt == '0) begin
          state_nxt = RUN;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are registered from the next state so the gate enable never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      cnt         <= '0;
      clk_en_o    <= 1'b1;
      sleeping_o  <= 1'b0;
      wake_ack_o  <= 1'b0;
      sleep_cnt_o <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clk_en_o   <= (state_nxt != SLEEP);
      sleeping_o <= (state_nxt == SLEEP) || (state_nxt == WAKE);
      wake_ack_o <= ack_nxt;
      if (sleep_cnt_clr_i) begin
        sleep_cnt_o <= '0;
      end else if ((state == SLEEP) && (sleep_cnt_o != '1)) begin
        sleep_cnt_o <= sleep_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
